// File: rtl/music_sequencer.sv
// music_sequencer: beat-indexed playback controller for the tone ROM.
// Steps ibeatNum at a fixed tempo (start / pause / stop / loop) and turns
// the ROM's tone frequency into a square wave on audio.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | stopped; beat, prescaler, phase accumulator and audio held at 0
//   PLAY  | prescaler advancing, beat stepping, audio synthesised from tone
//   PAUSE | prescaler, beat and phase frozen; audio held low
module music_sequencer #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned LAST_BEAT   = 63,
  parameter int unsigned SILENCE_HZ  = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [31:0] tone,
  output logic [7:0]  ibeatNum,
  output logic        playing,
  output logic        done,
  output logic        audio
);

  localparam int unsigned PW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(BEAT_CYCLES - 1);
  localparam logic [7:0]    BEAT_LAST  = 8'(LAST_BEAT);
  localparam logic [33:0]   ACC_MOD    = 34'(CLK_HZ);
  localparam logic [31:0]   TONE_REST  = 32'(SILENCE_HZ);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic [33:0]   acc_q, acc_nxt;
  logic [7:0]    beat_nxt;
  logic          audio_nxt;
  logic          done_nxt;

  // Phase accumulator step: adding 2*tone per clock and wrapping at CLK_HZ
  // toggles audio tone times per half-second, i.e. a tone-Hz square wave.
  // 34 bits hold acc (< CLK_HZ) plus 2*tone without overflow.
  logic          tone_rest;
  logic [33:0]   acc_sum;
  logic          acc_wrap;
  logic [33:0]   acc_step;
  logic          audio_step;
  logic          beat_end;

  assign tone_rest  = (tone == 32'd0) || (tone >= TONE_REST);
  assign acc_sum    = acc_q + {1'b0, tone, 1'b0};
  assign acc_wrap   = (acc_sum >= ACC_MOD);
  assign acc_step   = tone_rest ? 34'd0 : (acc_wrap ? (acc_sum - ACC_MOD) : acc_sum);
  assign audio_step = tone_rest ? 1'b0 : (audio ^ acc_wrap);
  assign beat_end   = (presc_q == PRESC_LAST);

  assign playing = (state != IDLE);

  // Next-state and datapath update; stop overrides pause, pause overrides start.
  always_comb begin
    state_nxt = state;
    beat_nxt  = ibeatNum;
    presc_nxt = presc_q;
    acc_nxt   = acc_q;
    audio_nxt = audio;
    done_nxt  = 1'b0;

    if (stop) begin
      state_nxt = IDLE;
      beat_nxt  = 8'd0;
      presc_nxt = '0;
      acc_nxt   = 34'd0;
      audio_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_nxt  = 8'd0;
          presc_nxt = '0;
          acc_nxt   = 34'd0;
          audio_nxt = 1'b0;
          if (start) begin
            state_nxt = PLAY;
          end
        end

        PLAY: begin
          if (pause) begin
            // Freeze counters and phase; speaker goes quiet while paused.
            state_nxt = PAUSE;
            audio_nxt = 1'b0;
          end else begin
            acc_nxt   = acc_step;
            audio_nxt = audio_step;
            if (beat_end) begin
              presc_nxt = '0;
              if (ibeatNum < BEAT_LAST) begin
                beat_nxt = ibeatNum + 8'd1;
              end else if (loop_en) begin
                beat_nxt = 8'd0;
              end else begin
                state_nxt = IDLE;
                beat_nxt  = 8'd0;
                acc_nxt   = 34'd0;
                audio_nxt = 1'b0;
                done_nxt  = 1'b1;
              end
            end else begin
              presc_nxt = presc_q + PW'(1);
            end
          end
        end

        PAUSE: begin
          // Resume at the frozen prescaler value; the resume cycle itself
          // does not advance the beat timer.
          if (!pause) begin
            state_nxt = PLAY;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ibeatNum <= 8'd0;
      presc_q  <= '0;
      acc_q    <= 34'd0;
      audio    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ibeatNum <= beat_nxt;
      presc_q  <= presc_nxt;
      acc_q    <= acc_nxt;
      audio    <= audio_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: scoreboard bench for music_sequencer.
// A cycle model pushes expected outputs when stimulus is applied; they are
// popped and compared once the DUT has clocked. Directed measurements
// (song length, toggle period, pause resume) add independent checks.
module tb_music_sequencer;

  localparam int CLK_HZ = 1000;
  localparam int BEAT   = 4;
  localparam int LAST   = 3;
  localparam int SIL    = 20000;
  localparam int SONG   = (LAST + 1) * BEAT;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pause;
  logic        stop;
  logic        loop_en;
  logic [31:0] tone;
  logic [7:0]  ibeatNum;
  logic        playing;
  logic        done;
  logic        audio;

  typedef struct packed {
    logic [7:0] beat;
    logic       playing;
    logic       done;
    logic       audio;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  // reference model: m_st 0=idle 1=play 2=pause; m_cnt = play cycles into song
  int m_st;
  int m_cnt;
  int m_acc;
  bit m_aud;
  bit m_done;

  music_sequencer #(
    .CLK_HZ     (CLK_HZ),
    .BEAT_CYCLES(BEAT),
    .LAST_BEAT  (LAST),
    .SILENCE_HZ (SIL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pause   (pause),
    .stop    (stop),
    .loop_en (loop_en),
    .tone    (tone),
    .ibeatNum(ibeatNum),
    .playing (playing),
    .done    (done),
    .audio   (audio)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_cnt  = 0;
    m_acc  = 0;
    m_aud  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (stop) begin
      m_st  = 0;
      m_cnt = 0;
      m_acc = 0;
      m_aud = 1'b0;
    end else if (m_st == 0) begin
      if (start) begin
        m_st  = 1;
        m_cnt = 0;
      end
    end else if (m_st == 2) begin
      if (!pause) m_st = 1;
    end else if (pause) begin
      m_st  = 2;
      m_aud = 1'b0;
    end else begin
      if (tone == 0 || tone >= SIL) begin
        m_acc = 0;
        m_aud = 1'b0;
      end else begin
        m_acc = m_acc + 2 * int'(tone);
        if (m_acc >= CLK_HZ) begin
          m_acc = m_acc - CLK_HZ;
          m_aud = !m_aud;
        end
      end
      m_cnt++;
      if (m_cnt == SONG) begin
        m_cnt = 0;
        if (!loop_en) begin
          m_st   = 0;
          m_done = 1'b1;
          m_acc  = 0;
          m_aud  = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    exp_t g;
    model_step();
    e.beat    = 8'(m_cnt / BEAT);
    e.playing = (m_st != 0);
    e.done    = m_done;
    e.audio   = m_aud;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    g = sb.pop_front();
    check("beat", 32'(ibeatNum), 32'(g.beat));
    check("playing", 32'(playing), 32'(g.playing));
    check("done", 32'(done), 32'(g.done));
    check("audio", 32'(audio), 32'(g.audio));
  endtask

  int  cnt;
  int  wraps;
  int  dones;
  int  ntog;
  int  last;
  int  n2;
  bit  seen;
  logic [7:0] prev_beat;
  logic       prev_aud;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    pause   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    tone    = 32'd0;
    model_reset();

    #12;
    check("rst_beat", 32'(ibeatNum), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_audio", 32'(audio), 32'd0);
    #1 rst = 1'b0;

    // pause with nothing playing is ignored
    pause = 1'b1;
    tick();
    tick();
    pause = 1'b0;

    // play once
    loop_en = 1'b0;
    start = 1'b1;
    tick();
    check("play_entry", 32'(playing), 32'd1);
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      cnt++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("song_len", 32'(cnt), 32'(SONG));
    check("end_playing", 32'(playing), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);

    // loop for three passes
    loop_en = 1'b1;
    start = 1'b1;
    tick();
    wraps = 0;
    dones = 0;
    prev_beat = ibeatNum;
    for (int i = 0; i < 3 * SONG; i++) begin
      tick();
      if (prev_beat == 8'(LAST) && ibeatNum == 8'd0) wraps++;
      if (done) dones++;
      prev_beat = ibeatNum;
    end
    check("loop_wraps", 32'(wraps), 32'd3);
    check("loop_dones", 32'(dones), 32'd0);
    check("loop_playing", 32'(playing), 32'd1);
    stop = 1'b1;
    tick();

    // audio period for tone=100 at CLK_HZ=1000: toggle every 5 cycles
    tone = 32'd100;
    start = 1'b1;
    tick();
    last = 0;
    ntog = 0;
    prev_aud = audio;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (audio != prev_aud) begin
        if (ntog < 4) check("tog_gap", 32'(i - last), 32'd5);
        ntog++;
        last = i;
      end
      prev_aud = audio;
    end
    check("tog_count", 32'(ntog >= 4), 32'd1);

    // silence threshold: rest, phase cleared
    tone = 32'(SIL);
    for (int i = 0; i < 3; i++) tick();
    check("rest_audio", 32'(audio), 32'd0);
    tone = 32'd100;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      cnt++;
      if (audio) seen = 1'b1;
    end
    check("restart_gap", 32'(cnt), 32'd5);
    tone = 32'd0;
    for (int i = 0; i < 3; i++) tick();
    check("zero_audio", 32'(audio), 32'd0);
    stop = 1'b1;
    tick();

    // pause at beat 2, prescaler 1, for 7 cycles
    tone    = 32'd100;
    loop_en = 1'b0;
    start   = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) tick();
    check("pre_pause_beat", 32'(ibeatNum), 32'd2);
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("pause_beat", 32'(ibeatNum), 32'd2);
      check("pause_audio", 32'(audio), 32'd0);
    end
    pause = 1'b0;
    n2 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ibeatNum != 8'd2) break;
      n2++;
    end
    check("beat2_rest", 32'(n2), 32'd3);
    check("after_pause_beat", 32'(ibeatNum), 32'd3);
    stop = 1'b1;
    tick();

    // stop and start together while playing
    start = 1'b1;
    tick();
    tick();
    tick();
    stop  = 1'b1;
    start = 1'b1;
    tick();
    check("coll_playing", 32'(playing), 32'd0);
    check("coll_beat", 32'(ibeatNum), 32'd0);
    check("coll_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1;
    tick();
    for (int i = 0; i < BEAT; i++) tick();
    check("restart_beat", 32'(ibeatNum), 32'd1);
    stop = 1'b1;
    tick();

    // asynchronous reset mid-beat 1
    start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_beat", 32'(ibeatNum), 32'd0);
    check("arst_playing", 32'(playing), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_audio", 32'(audio), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    check("arst_idle", 32'(playing), 32'd0);
    start = 1'b1;
    tick();
    check("arst_restart", 32'(playing), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
